rdm_harq_combiner: RTL and testbench
====================================

// Module: rdm_harq_combiner
// PURPOSE
//  Downstream consumer of the rate-dematch (RDM) data stream. Requests one RDM burst, splits each 96-bit word into
//  16 signed 6-bit LLRs and combines them lane-wise into the per-user HARQ soft buffer (read-add-saturate-write);
//  first transmissions overwrite instead. Sits between the RDM send FSM and the HARQ soft-buffer RAM.
// PARAMETERS
//  LLR_W   6   bits per signed LLR lane; saturation range is +/-(2^(LLR_W-1)-1) = +/-31
//  LANES   16  LLR lanes per word; data width DW = LLR_W*LANES = 96
//  ADDR_W  12  HARQ RAM word address width
// PORTS
//  i_core_clk          in   1       core clock, all logic on rising edge
//  i_rx_rstn           in   1       reset, synchronous, active-low
//  i_combine_start     in   1       1-cycle start pulse; ignored unless IDLE
//  i_ncb_size          in   16      soft-bit count for this user, sampled at start
//  i_first_tx          in   1       1 = overwrite (old value taken as 0), sampled at start
//  i_harq_base_addr    in   ADDR_W  first HARQ word address, sampled at start
//  o_rdm_data_request  out  1       1-cycle pulse asking the RDM FSM for the burst
//  i_rdm_data_valid    in   1       beat qualifier
//  i_rdm_data_comp     in   1       end-of-burst flag from RDM FSM
//  i_rdm_data_content  in   DW      lane j = bits [LLR_W*j +: LLR_W]
//  o_harq_rd_en        out  1       RAM read strobe, read data valid exactly 1 cycle later
//  o_harq_rd_addr      out  ADDR_W  RAM read address
//  i_harq_rd_data      in   DW      RAM read data
//  o_harq_wr_en        out  1       RAM write strobe
//  o_harq_wr_addr      out  ADDR_W  RAM write address
//  o_harq_wr_data      out  DW      combined word
//  o_combine_busy      out  1       high in every state except IDLE
//  o_combine_done      out  1       1-cycle pulse at end of job
//  o_len_err           out  1       sticky per job: burst length mismatch; cleared on accepted start
//  o_sat_count         out  16      lanes saturated in this job (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, pipeline flushed. Reset mid-job drops in-flight writes; no write after reset edge.
//  n_words = ncb[15:4] + (ncb[3:0]!=0), 13-bit; last word valid lanes = ncb[3:0] (0 means all 16).
//  FSM: IDLE -start-> REQ (latch size/mode/base; if ncb==0 go DONE directly, no request)
//       REQ: request=1 for exactly one cycle -> RECV
//       RECV: each valid beat k (k=0..n_words-1): rd_en=1, rd_addr=(base+k) mod 2^ADDR_W, beat data staged
//             -> DRAIN when k reaches n_words-1 accepted, or on comp (same beat counts if valid=1)
//             comp with fewer than n_words beats: o_len_err=1. Beats beyond n_words: ignored, o_len_err=1.
//       DRAIN: wait until pipeline empty (last write issued) -> DONE
//       DONE: o_combine_done=1 one cycle, busy still 1 -> IDLE
//  Pipeline: beat at cycle t -> read at t -> add at t+1 (registered) -> wr_en at t+2, wr_addr=rd_addr of beat.
//  Throughput one beat per cycle, back-to-back valid allowed; addresses strictly increasing, no RAW hazard.
//  Lane math: sum = new + (first_tx ? 0 : old), LLR_W+1 bits signed; clamp to [-31,+31]. Incoming -32 also clamps
//   to -31 (counts as saturation). Masked lanes of last partial word write back old value unchanged (0 if first_tx).
//  Address wrap: base+k beyond 2^ADDR_W-1 wraps to 0; no error.
//  Start while busy: ignored. Valid outside RECV: ignored.
// CONFIGURATION
//  RDM_COMB_SAT_CNT_EN defined: o_sat_count counts saturated active lanes per job, cleared at accepted start,
//   sticks at 16'hFFFF. Undefined: o_sat_count tied to 0, counter logic absent.
// TESTING
//  1. ncb=32, first_tx=1, base=0, 2 beats all lanes +5 -> wr addr 0,1 data all +5 at t+2; done 1 cycle after last wr
//  2. old all +20, ncb=16, first_tx=0, new all +20 -> wr data all +31, sat_count=16 (with _EN), len_err=0
//  3. ncb=20, old all +7, new all +1 -> word0 all +8; word1 lanes0..3 = +8, lanes4..15 = +7
//  4. ncb=48, comp with 1st beat -> 1 write, len_err=1, done pulse, IDLE; next start clears len_err
//  5. base=4095, ncb=32 -> writes at 4095 then 0
//  6. first_tx=1, lane=-32 -> -31; reset asserted mid-RECV -> next cycle all outputs 0, no further wr_en

Source files
------------

// File: rtl/rdm_harq_combiner.sv
// rdm_harq_combiner
//   Takes one RDM burst and folds it into the per-user HARQ soft buffer.
//   Each 96-bit beat is split into 16 signed 6-bit LLRs. Each lane computes
//   new + old (old is taken as 0 on a first transmission) and clamps the
//   result to +/-31 before it is written back.
//   Pipeline: beat/read at t, add registered at t+1, write issued at t+2.
//   Optional macro RDM_COMB_SAT_CNT_EN: adds the per-job saturated-lane
//   counter on o_sat_count. When the macro is undefined, o_sat_count is 0.
// Ports
//   i_core_clk, i_rx_rstn                      clock, sync active-low reset
//   i_combine_start/i_ncb_size/i_first_tx/
//   i_harq_base_addr                           job start and job parameters
//   o_rdm_data_request, i_rdm_data_*           RDM burst handshake and data
//   o_harq_rd_*, i_harq_rd_data                soft-buffer read (1-cycle latency)
//   o_harq_wr_*                                soft-buffer write
//   o_combine_busy/done, o_len_err, o_sat_count job status

module rdm_harq_lane #(
  parameter int LLR_W = 6
) (
  input  logic [LLR_W-1:0] new_llr,
  input  logic [LLR_W-1:0] old_llr,
  input  logic             first_tx,
  input  logic             active,
`ifdef RDM_COMB_SAT_CNT_EN
  output logic             sat,
`endif
  output logic [LLR_W-1:0] out_llr
);
  localparam int                 MAXI = 2**(LLR_W-1) - 1;
  localparam logic signed [LLR_W:0] POS = MAXI[LLR_W:0];
  localparam logic signed [LLR_W:0] NEG = -POS;

  logic signed [LLR_W:0] new_ext, old_ext, sum;
  logic                  sat_c;

  always_comb begin
    new_ext = {new_llr[LLR_W-1], new_llr};
    old_ext = first_tx ? '0 : {old_llr[LLR_W-1], old_llr};
    sum     = new_ext + old_ext;
    sat_c   = 1'b0;
    out_llr = sum[LLR_W-1:0];
    if (!active) begin
      // lanes past the end of the soft buffer keep their stored value
      out_llr = first_tx ? '0 : old_llr;
    end else if (sum > POS) begin
      out_llr = POS[LLR_W-1:0];
      sat_c   = 1'b1;
    end else if (sum < NEG) begin
      // this also catches an incoming -32 on a first transmission
      out_llr = NEG[LLR_W-1:0];
      sat_c   = 1'b1;
    end
  end

`ifdef RDM_COMB_SAT_CNT_EN
  assign sat = sat_c;
`endif
endmodule

module rdm_harq_combiner #(
  parameter  int LLR_W  = 6,
  parameter  int LANES  = 16,
  parameter  int ADDR_W = 12,
  localparam int DW     = LLR_W * LANES
) (
  input  logic              i_core_clk,
  input  logic              i_rx_rstn,
  input  logic              i_combine_start,
  input  logic [15:0]       i_ncb_size,
  input  logic              i_first_tx,
  input  logic [ADDR_W-1:0] i_harq_base_addr,
  output logic              o_rdm_data_request,
  input  logic              i_rdm_data_valid,
  input  logic              i_rdm_data_comp,
  input  logic [DW-1:0]     i_rdm_data_content,
  output logic              o_harq_rd_en,
  output logic [ADDR_W-1:0] o_harq_rd_addr,
  input  logic [DW-1:0]     i_harq_rd_data,
  output logic              o_harq_wr_en,
  output logic [ADDR_W-1:0] o_harq_wr_addr,
  output logic [DW-1:0]     o_harq_wr_data,
  output logic              o_combine_busy,
  output logic              o_combine_done,
  output logic              o_len_err,
  output logic [15:0]       o_sat_count
);
  localparam int LW = $clog2(LANES);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d, busy_q, busy_d, done_q, done_d;
  logic                len_err_q, len_err_d, first_tx_q, first_tx_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [12:0]         n_words_q, n_words_d, cnt_q, cnt_d;
  logic [LW-1:0]       last_lanes_q, last_lanes_d;
  // vld_pipe[0]: add stage holds a beat, vld_pipe[1]: write stage holds a word
  logic [1:0]          vld_pipe_q, vld_pipe_d;
  logic [DW-1:0]       s1_data_q, s1_data_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic [LANES-1:0]    s1_mask_q, s1_mask_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]       wr_data_q, wr_data_d;

  logic                      start_acc, rd_en, partial;
  logic [ADDR_W-1:0]         rd_addr;
  logic [LANES-1:0]          beat_mask;
  logic [LANES-1:0][LLR_W-1:0] new_l, old_l, out_l;

  assign new_l = s1_data_q;
  assign old_l = i_harq_rd_data;

`ifdef RDM_COMB_SAT_CNT_EN
  logic [LANES-1:0]          lane_sat;
  logic [$clog2(LANES+1)-1:0] sat_lanes;
  logic [16:0]               sat_sum;
  logic [15:0]               sat_cnt_q, sat_cnt_d;
`endif

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    rdm_harq_lane #(.LLR_W(LLR_W)) u_lane (
      .new_llr  (new_l[j]),
      .old_llr  (old_l[j]),
      .first_tx (first_tx_q),
      .active   (s1_mask_q[j]),
`ifdef RDM_COMB_SAT_CNT_EN
      .sat      (lane_sat[j]),
`endif
      .out_llr  (out_l[j])
    );
  end

  assign start_acc = (state_q == S_IDLE) && i_combine_start;

  always_comb begin
    state_d      = state_q;
    len_err_d    = len_err_q;
    first_tx_d   = first_tx_q;
    base_d       = base_q;
    n_words_d    = n_words_q;
    last_lanes_d = last_lanes_q;
    cnt_d        = cnt_q;
    vld_pipe_d   = {vld_pipe_q[0], 1'b0};
    s1_data_d    = s1_data_q;
    s1_addr_d    = s1_addr_q;
    s1_mask_d    = s1_mask_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_en        = 1'b0;
    rd_addr      = '0;

    // only the last word of a non-multiple-of-16 buffer is partial
    partial = (cnt_q == n_words_q - 13'd1) && (last_lanes_q != '0);
    for (int j = 0; j < LANES; j++)
      beat_mask[j] = !partial || (LW'(j) < last_lanes_q);

    case (state_q)
      S_IDLE: if (i_combine_start) begin
        first_tx_d   = i_first_tx;
        base_d       = i_harq_base_addr;
        n_words_d    = 13'(i_ncb_size >> LW) + 13'(|i_ncb_size[LW-1:0]);
        last_lanes_d = i_ncb_size[LW-1:0];
        cnt_d        = '0;
        len_err_d    = 1'b0;
        state_d      = (i_ncb_size == '0) ? S_DONE : S_REQ;
      end
      S_REQ: state_d = S_RECV;
      S_RECV: begin
        if (i_rdm_data_valid) begin
          rd_en         = 1'b1;
          rd_addr       = base_q + ADDR_W'(cnt_q);
          vld_pipe_d[0] = 1'b1;
          s1_data_d     = i_rdm_data_content;
          s1_addr_d     = rd_addr;
          s1_mask_d     = beat_mask;
          cnt_d         = cnt_q + 13'd1;
          if (cnt_q == n_words_q - 13'd1) begin
            state_d = S_DRAIN;
          end else if (i_rdm_data_comp) begin
            state_d   = S_DRAIN;
            len_err_d = 1'b1;
          end
        end else if (i_rdm_data_comp) begin
          state_d   = S_DRAIN;
          len_err_d = 1'b1;
        end
      end
      S_DRAIN: begin
        // beats arriving after the burst was closed are surplus
        if (i_rdm_data_valid) len_err_d = 1'b1;
        if (!vld_pipe_q[0])   state_d   = S_DONE;
      end
      S_DONE: begin
        if (i_rdm_data_valid) len_err_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (vld_pipe_q[0]) begin
      wr_addr_d = s1_addr_q;
      wr_data_d = out_l;
    end

    req_d  = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

`ifdef RDM_COMB_SAT_CNT_EN
  always_comb begin
    sat_lanes = '0;
    for (int j = 0; j < LANES; j++)
      sat_lanes = sat_lanes + $bits(sat_lanes)'(lane_sat[j]);
    sat_sum   = {1'b0, sat_cnt_q} + 17'(sat_lanes);
    sat_cnt_d = sat_cnt_q;
    if (start_acc)         sat_cnt_d = '0;
    else if (vld_pipe_q[0]) sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
  assign o_sat_count = sat_cnt_q;
`else
  assign o_sat_count = '0;
`endif

  always_ff @(posedge i_core_clk) begin
    if (!i_rx_rstn) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      len_err_q    <= 1'b0;
      first_tx_q   <= 1'b0;
      base_q       <= '0;
      n_words_q    <= '0;
      last_lanes_q <= '0;
      cnt_q        <= '0;
      vld_pipe_q   <= '0;
      s1_data_q    <= '0;
      s1_addr_q    <= '0;
      s1_mask_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
`ifdef RDM_COMB_SAT_CNT_EN
      sat_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      len_err_q    <= len_err_d;
      first_tx_q   <= first_tx_d;
      base_q       <= base_d;
      n_words_q    <= n_words_d;
      last_lanes_q <= last_lanes_d;
      cnt_q        <= cnt_d;
      vld_pipe_q   <= vld_pipe_d;
      s1_data_q    <= s1_data_d;
      s1_addr_q    <= s1_addr_d;
      s1_mask_q    <= s1_mask_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
`ifdef RDM_COMB_SAT_CNT_EN
      sat_cnt_q    <= sat_cnt_d;
`endif
    end
  end

  assign o_rdm_data_request = req_q;
  assign o_combine_busy     = busy_q;
  assign o_combine_done     = done_q;
  assign o_len_err          = len_err_q;
  assign o_harq_rd_en       = rd_en;
  assign o_harq_rd_addr     = rd_addr;
  assign o_harq_wr_en       = vld_pipe_q[1];
  assign o_harq_wr_addr     = wr_addr_q;
  assign o_harq_wr_data     = wr_data_q;
endmodule

// File: tb/tb_rdm_harq_combiner.sv
module tb_rdm_harq_combiner;
  logic        clk = 1'b0;
  logic        rstn;
  logic        start, first_tx, valid, comp;
  logic [15:0] ncb;
  logic [11:0] base;
  logic [95:0] content;
  logic        req, rd_en, wr_en, busy, done, len_err;
  logic [11:0] rd_addr, wr_addr;
  logic [95:0] rd_data, wr_data;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  rdm_harq_combiner dut (
    .i_core_clk(clk), .i_rx_rstn(rstn),
    .i_combine_start(start), .i_ncb_size(ncb), .i_first_tx(first_tx),
    .i_harq_base_addr(base), .o_rdm_data_request(req),
    .i_rdm_data_valid(valid), .i_rdm_data_comp(comp),
    .i_rdm_data_content(content),
    .o_harq_rd_en(rd_en), .o_harq_rd_addr(rd_addr), .i_harq_rd_data(rd_data),
    .o_harq_wr_en(wr_en), .o_harq_wr_addr(wr_addr), .o_harq_wr_data(wr_data),
    .o_combine_busy(busy), .o_combine_done(done), .o_len_err(len_err),
    .o_sat_count(sat_count)
  );

  // soft-buffer RAM model plus write/request/done logging
  logic [95:0] ram [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr;
  logic [95:0] pl_data;
  int          cyc = 0, req_cnt = 0, done_cyc = 0;
  logic [11:0] wa[$];
  logic [95:0] wd[$];
  int          wc[$];
  int          errors = 0, checks = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) ram[pl_addr] <= pl_data;
    if (rd_en) rd_data <= ram[rd_addr];
    if (wr_en) begin
      ram[wr_addr] <= wr_data;
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      wc.push_back(cyc);
    end
    if (req)  req_cnt  <= req_cnt + 1;
    if (done) done_cyc <= cyc;
  end

  function automatic logic [95:0] rep(input logic [5:0] v);
    return {16{v}};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [95:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic start_job(input logic [15:0] n, input logic f, input logic [11:0] b);
    tick();
    start = 1'b1; ncb = n; first_tx = f; base = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req && n < 20) begin tick(); n++; end
    checks++;
    if (req !== 1'b1) begin $display("FAIL req_timeout got %b exp 1", req); errors++; end
  endtask

  task automatic send(input int n, input logic [95:0] d0, input logic [95:0] d1,
                      input bit comp_last, output int first_cyc);
    first_cyc = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      valid = 1'b1;
      content = (i == 0) ? d0 : d1;
      comp = comp_last && (i == n - 1);
      if (i == 0) first_cyc = cyc;
    end
    tick();
    valid = 1'b0; comp = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 30) begin tick(); n++; end
    checks++;
    if (done !== 1'b1) begin $display("FAIL done_timeout got %b exp 1", done); errors++; end
    tick();
  endtask

  int exp_sat16, exp_sat1;

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0)    begin $display("FAIL rst_busy got %b exp 0", busy); errors++; end
    checks++; if (req !== 1'b0)     begin $display("FAIL rst_req got %b exp 0", req); errors++; end
    checks++; if (wr_en !== 1'b0)   begin $display("FAIL rst_wr_en got %b exp 0", wr_en); errors++; end
    checks++; if (rd_en !== 1'b0)   begin $display("FAIL rst_rd_en got %b exp 0", rd_en); errors++; end
    checks++; if (done !== 1'b0)    begin $display("FAIL rst_done got %b exp 0", done); errors++; end
    checks++; if (len_err !== 1'b0) begin $display("FAIL rst_len_err got %b exp 0", len_err); errors++; end
    checks++; if (sat_count !== 16'd0) begin $display("FAIL rst_sat got %0d exp 0", sat_count); errors++; end
    checks++; if (wr_data !== 96'd0) begin $display("FAIL rst_wr_data got %h exp 0", wr_data); errors++; end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_first_tx();
    int w0, r0, bc;
    preload(12'd0, rep(6'd9));
    preload(12'd1, rep(6'd9));
    w0 = wa.size(); r0 = req_cnt;
    start_job(16'd32, 1'b1, 12'd0);
    wait_req();
    send(2, rep(6'd5), rep(6'd5), 1'b1, bc);
    wait_done();
    checks++; if (wa.size() - w0 != 2) begin $display("FAIL t1_nwr got %0d exp 2", wa.size() - w0); errors++; end
    if (wa.size() >= w0 + 2) begin
      checks++; if (wa[w0] !== 12'd0)   begin $display("FAIL t1_addr0 got %0d exp 0", wa[w0]); errors++; end
      checks++; if (wa[w0+1] !== 12'd1) begin $display("FAIL t1_addr1 got %0d exp 1", wa[w0+1]); errors++; end
      checks++; if (wd[w0] !== rep(6'd5))   begin $display("FAIL t1_data0 got %h exp %h", wd[w0], rep(6'd5)); errors++; end
      checks++; if (wd[w0+1] !== rep(6'd5)) begin $display("FAIL t1_data1 got %h exp %h", wd[w0+1], rep(6'd5)); errors++; end
      checks++; if (wc[w0] != bc + 2)   begin $display("FAIL t1_lat0 got %0d exp %0d", wc[w0], bc + 2); errors++; end
      checks++; if (wc[w0+1] != bc + 3) begin $display("FAIL t1_lat1 got %0d exp %0d", wc[w0+1], bc + 3); errors++; end
    end
    checks++; if (done_cyc != bc + 4) begin $display("FAIL t1_done_cyc got %0d exp %0d", done_cyc, bc + 4); errors++; end
    checks++; if (req_cnt - r0 != 1)  begin $display("FAIL t1_req_pulses got %0d exp 1", req_cnt - r0); errors++; end
    checks++; if (len_err !== 1'b0)   begin $display("FAIL t1_len_err got %b exp 0", len_err); errors++; end
    checks++; if (busy !== 1'b0)      begin $display("FAIL t1_idle got %b exp 0", busy); errors++; end
  endtask

  task automatic test_saturate();
    int w0, bc;
    preload(12'd100, rep(6'd20));
    w0 = wa.size();
    start_job(16'd16, 1'b0, 12'd100);
    wait_req();
    send(1, rep(6'd20), '0, 1'b1, bc);
    wait_done();
    checks++; if (wa.size() - w0 != 1) begin $display("FAIL t2_nwr got %0d exp 1", wa.size() - w0); errors++; end
    if (wa.size() > w0) begin
      checks++; if (wd[w0] !== rep(6'd31)) begin $display("FAIL t2_data got %h exp %h", wd[w0], rep(6'd31)); errors++; end
    end
    checks++; if (sat_count !== 16'(exp_sat16)) begin $display("FAIL t2_sat got %0d exp %0d", sat_count, exp_sat16); errors++; end
    checks++; if (len_err !== 1'b0) begin $display("FAIL t2_len_err got %b exp 0", len_err); errors++; end
  endtask

  task automatic test_partial();
    int w0, bc;
    logic [95:0] e1;
    e1 = rep(6'd7);
    e1[23:0] = {4{6'd8}};
    preload(12'd200, rep(6'd7));
    preload(12'd201, rep(6'd7));
    w0 = wa.size();
    start_job(16'd20, 1'b0, 12'd200);
    wait_req();
    send(2, rep(6'd1), rep(6'd1), 1'b1, bc);
    wait_done();
    checks++; if (wa.size() - w0 != 2) begin $display("FAIL t3_nwr got %0d exp 2", wa.size() - w0); errors++; end
    if (wa.size() >= w0 + 2) begin
      checks++; if (wd[w0] !== rep(6'd8)) begin $display("FAIL t3_word0 got %h exp %h", wd[w0], rep(6'd8)); errors++; end
      checks++; if (wd[w0+1] !== e1)      begin $display("FAIL t3_word1 got %h exp %h", wd[w0+1], e1); errors++; end
    end
    checks++; if (sat_count !== 16'd0) begin $display("FAIL t3_sat got %0d exp 0", sat_count); errors++; end
  endtask

  task automatic test_short_burst();
    int w0, bc;
    w0 = wa.size();
    start_job(16'd48, 1'b1, 12'd300);
    wait_req();
    send(1, rep(6'd3), '0, 1'b1, bc);
    wait_done();
    checks++; if (wa.size() - w0 != 1) begin $display("FAIL t4_nwr got %0d exp 1", wa.size() - w0); errors++; end
    if (wa.size() > w0) begin
      checks++; if (wd[w0] !== rep(6'd3)) begin $display("FAIL t4_data got %h exp %h", wd[w0], rep(6'd3)); errors++; end
    end
    checks++; if (len_err !== 1'b1) begin $display("FAIL t4_len_err got %b exp 1", len_err); errors++; end
    checks++; if (busy !== 1'b0)    begin $display("FAIL t4_idle got %b exp 0", busy); errors++; end
  endtask

  task automatic test_addr_wrap();
    int w0, bc;
    w0 = wa.size();
    start_job(16'd32, 1'b1, 12'd4095);
    checks++; if (len_err !== 1'b0) begin $display("FAIL t5_len_err_clr got %b exp 0", len_err); errors++; end
    wait_req();
    send(2, rep(6'd2), rep(6'd2), 1'b0, bc);
    wait_done();
    checks++; if (wa.size() - w0 != 2) begin $display("FAIL t5_nwr got %0d exp 2", wa.size() - w0); errors++; end
    if (wa.size() >= w0 + 2) begin
      checks++; if (wa[w0] !== 12'd4095) begin $display("FAIL t5_addr0 got %0d exp 4095", wa[w0]); errors++; end
      checks++; if (wa[w0+1] !== 12'd0)  begin $display("FAIL t5_addr1 got %0d exp 0", wa[w0+1]); errors++; end
    end
    checks++; if (len_err !== 1'b0) begin $display("FAIL t5_len_err got %b exp 0", len_err); errors++; end
  endtask

  task automatic test_neg_clamp();
    int w0, bc;
    logic [95:0] d, e;
    d = rep(6'd4); d[5:0] = 6'b100000;
    e = rep(6'd4); e[5:0] = 6'b100001;
    w0 = wa.size();
    start_job(16'd16, 1'b1, 12'd500);
    wait_req();
    send(1, d, '0, 1'b1, bc);
    wait_done();
    if (wa.size() > w0) begin
      checks++; if (wd[w0] !== e) begin $display("FAIL t6_clamp got %h exp %h", wd[w0], e); errors++; end
    end
    checks++; if (sat_count !== 16'(exp_sat1)) begin $display("FAIL t6_sat got %0d exp %0d", sat_count, exp_sat1); errors++; end
  endtask

  task automatic test_reset_mid();
    int w0, w1;
    w0 = wa.size();
    start_job(16'd64, 1'b1, 12'd600);
    wait_req();
    tick(); valid = 1'b1; content = rep(6'd1);
    tick(); content = rep(6'd2);
    tick(); valid = 1'b0; rstn = 1'b0;
    tick();
    checks++; if (busy !== 1'b0)  begin $display("FAIL t7_busy got %b exp 0", busy); errors++; end
    checks++; if (wr_en !== 1'b0) begin $display("FAIL t7_wr_en got %b exp 0", wr_en); errors++; end
    checks++; if (rd_en !== 1'b0) begin $display("FAIL t7_rd_en got %b exp 0", rd_en); errors++; end
    checks++; if (wr_addr !== 12'd0) begin $display("FAIL t7_wr_addr got %0d exp 0", wr_addr); errors++; end
    checks++; if (sat_count !== 16'd0) begin $display("FAIL t7_sat got %0d exp 0", sat_count); errors++; end
    w1 = wa.size();
    repeat (5) tick();
    checks++; if (wa.size() != w1) begin $display("FAIL t7_late_wr got %0d exp %0d", wa.size(), w1); errors++; end
    checks++; if (w1 - w0 != 1)    begin $display("FAIL t7_nwr got %0d exp 1", w1 - w0); errors++; end
    rstn = 1'b1;
    tick();
  endtask

  initial begin
`ifdef RDM_COMB_SAT_CNT_EN
    exp_sat16 = 16; exp_sat1 = 1;
`else
    exp_sat16 = 0;  exp_sat1 = 0;
`endif
    rstn = 1'b0; start = 1'b0; first_tx = 1'b0; valid = 1'b0; comp = 1'b0;
    ncb = '0; base = '0; content = '0;
    test_reset();
    test_first_tx();
    test_saturate();
    test_partial();
    test_short_burst();
    test_addr_wrap();
    test_neg_clamp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
